// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, sync polarity encodings and a sync level helper.
package vga_timing_gen_pkg;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz nominal pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam logic VGA640_HS_POL = POL_ACTIVE_LOW;
    localparam logic VGA640_VS_POL = POL_ACTIVE_LOW;

    // 800x600 @ 60 Hz, 40 MHz nominal pixel clock
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam logic SVGA800_HS_POL = POL_ACTIVE_HIGH;
    localparam logic SVGA800_VS_POL = POL_ACTIVE_HIGH;

    function automatic logic sync_level(input logic pol, input logic in_window);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of vga_timing_gen bundled for connection to a pixel source.
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             pix_en;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             active;
    logic             line_start;
    logic             frame_start;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_blank_n;
    logic             vga_sync_n;

    modport master (
        output pix_en, h_count, v_count, active, line_start, frame_start,
               vga_hs, vga_vs, vga_blank_n, vga_sync_n
    );

    modport slave (
        input  pix_en, h_count, v_count, active, line_start, frame_start,
               vga_hs, vga_vs, vga_blank_n, vga_sync_n
    );
endinterface

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    genvar gi;

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, en};
            assign dout = din;
        end else begin : g_pipe
            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] q_reg;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (rst)     q_reg <= RST_VAL;
                        else if (en) q_reg <= din;
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (rst)     q_reg <= RST_VAL;
                        else if (en) q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
            assign dout = g_stage[DEPTH-1].q_reg;
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider, h/v counters, sync/blank decode and output alignment pipe.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic HS_POL   = VGA640_HS_POL,
    parameter logic VS_POL   = VGA640_VS_POL,
    parameter int   CLK_DIV  = 2,
    parameter int   PIPE     = 2,
    parameter int   CNT_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] clk_div_reg;
    logic [CNT_W-1:0] h_count_reg;
    logic [CNT_W-1:0] v_count_reg;
    logic             pix_en;
    logic             hs;
    logic             vs;
    logic             active;
    logic [2:0]       video_ctl;
    logic [2:0]       video_ctl_dly;

    // Gated by rst so no tick escapes while the counters are being cleared.
    assign pix_en = en && !rst && (clk_div_reg == DIV_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_div_reg <= '0;
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else if (en) begin
            clk_div_reg <= (clk_div_reg == DIV_MAX) ? '0 : clk_div_reg + DIV_W'(1);
            if (pix_en) begin
                if (h_count_reg == H_MAX) begin
                    h_count_reg <= '0;
                    v_count_reg <= (v_count_reg == V_MAX) ? '0 : v_count_reg + CNT_W'(1);
                end else begin
                    h_count_reg <= h_count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign active = (h_count_reg < CNT_W'(H_ACTIVE)) && (v_count_reg < CNT_W'(V_ACTIVE));
    assign hs = sync_level(HS_POL, (h_count_reg >= HS_BEGIN) && (h_count_reg < HS_END));
    assign vs = sync_level(VS_POL, (v_count_reg >= VS_BEGIN) && (v_count_reg < VS_END));

    // Sync/blank ride one pipe so they stay aligned with downstream pixel latency.
    assign video_ctl = {hs, vs, active};

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE),
        .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  (video_ctl),
        .dout (video_ctl_dly)
    );

    assign vga.pix_en      = pix_en;
    assign vga.h_count     = h_count_reg;
    assign vga.v_count     = v_count_reg;
    assign vga.active      = active;
    assign vga.line_start  = pix_en && (h_count_reg == '0);
    assign vga.frame_start = pix_en && (h_count_reg == '0) && (v_count_reg == '0);
    assign vga.vga_hs      = video_ctl_dly[2];
    assign vga.vga_vs      = video_ctl_dly[1];
    assign vga.vga_blank_n = video_ctl_dly[0];
    assign vga.vga_sync_n  = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing plus two reduced rasters.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en_def;
    logic en_small;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen_if #(.CNT_W(11)) if_def ();
    vga_timing_gen_if #(.CNT_W(4))  if_small ();
    vga_timing_gen_if #(.CNT_W(4))  if_pol ();

    vga_timing_gen u_def (
        .clk (clk), .rst (rst), .en (en_def), .vga (if_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .PIPE(3), .CNT_W(4)
    ) u_small (
        .clk (clk), .rst (rst), .en (en_small), .vga (if_small)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .CLK_DIV(1), .PIPE(0), .CNT_W(4)
    ) u_pol (
        .clk (clk), .rst (rst), .en (en_small), .vga (if_pol)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [2:0] sb_q[$];

    initial begin
        int h, v, c0, c1, lo_cnt, bl_cnt, first_lo, v_hold, i;
        logic hs_u, vs_u, bl_u;
        logic [2:0] exp_ctl;

        rst = 1'b1;
        en_def = 1'b1;
        en_small = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_h", if_def.h_count, 0);
        chk("rst_v", if_def.v_count, 0);
        chk("rst_pix_en", if_def.pix_en, 0);
        chk("rst_hs", if_def.vga_hs, 1);
        chk("rst_vs", if_def.vga_vs, 1);
        chk("rst_blank", if_def.vga_blank_n, 0);
        chk("sync_n", if_def.vga_sync_n, 0);
        chk("rst_small_ctl", {if_small.vga_hs, if_small.vga_vs, if_small.vga_blank_n}, 3'b110);
        chk("rst_pol_hs", if_pol.vga_hs, 0);
        chk("rst_pol_vs", if_pol.vga_vs, 0);
        $display("reset state checked at cycle %0d", cyc);

        // Small raster: pipe starts holding three inactive stages
        rst = 1'b0;
        repeat (3) sb_q.push_back(3'b110);
        for (int k = 0; k < 100; k++) begin
            #1;
            h = k % 8;
            v = (k / 8) % 6;
            hs_u = !(h >= 5 && h < 7);
            vs_u = (v != 4);
            bl_u = (h < 4) && (v < 3);
            chk("small_h", if_small.h_count, h);
            chk("small_v", if_small.v_count, v);
            chk("small_pix_en", if_small.pix_en, 1);
            chk("small_frame_start", if_small.frame_start, (k % 48) == 0);
            sb_q.push_back({hs_u, vs_u, bl_u});
            exp_ctl = sb_q.pop_front();
            chk("small_pipe_ctl", {if_small.vga_hs, if_small.vga_vs, if_small.vga_blank_n}, exp_ctl);
            chk("pol_hs", if_pol.vga_hs, !hs_u);
            chk("pol_vs", if_pol.vga_vs, !vs_u);
            if (k == 0) chk("def_first_pix_en0", if_def.pix_en, 0);
            if (k == 1) chk("def_first_pix_en1", if_def.pix_en, 1);
            if (k == 1) chk("def_first_frame_start", if_def.frame_start, 1);
            $display("small k=%0d h=%0d v=%0d ctl=%b exp=%b", k, if_small.h_count,
                     if_small.v_count, {if_small.vga_hs, if_small.vga_vs, if_small.vga_blank_n}, exp_ctl);
            @(negedge clk);
        end

        // Default line period
        for (i = 0; i < 4000 && !if_def.line_start; i++) @(negedge clk);
        chk("line_start_found", if_def.line_start, 1);
        c0 = cyc;
        @(negedge clk);
        for (i = 0; i < 4000 && !if_def.line_start; i++) @(negedge clk);
        chk("line_start_found2", if_def.line_start, 1);
        c1 = cyc;
        chk("line_period", c1 - c0, 1600);
        chk("line_start_h", if_def.h_count, 0);
        $display("line period %0d clks, v=%0d", c1 - c0, if_def.v_count);

        // hs window over one full line (output delayed by 2 ticks)
        lo_cnt = 0;
        bl_cnt = 0;
        first_lo = -1;
        for (int k = 0; k < 1600; k++) begin
            if (!if_def.vga_hs) begin
                if (first_lo < 0) first_lo = int'(if_def.h_count);
                lo_cnt++;
            end
            if (if_def.vga_blank_n) bl_cnt++;
            @(negedge clk);
        end
        chk("hs_low_clks", lo_cnt, 192);
        chk("hs_first_low_h", first_lo, 658);
        chk("blank_n_high_clks", bl_cnt, 1280);
        $display("hs low %0d clks from h=%0d, blank_n high %0d clks", lo_cnt, first_lo, bl_cnt);

        // en low for 37 clks at h=100
        for (i = 0; i < 2000 && if_def.h_count != 11'd100; i++) @(negedge clk);
        chk("reach_h100", if_def.h_count, 100);
        v_hold = int'(if_def.v_count);
        en_def = 1'b0;
        for (int k = 0; k < 37; k++) begin
            #1;
            chk("hold_h", if_def.h_count, 100);
            chk("hold_pix_en", if_def.pix_en, 0);
            @(negedge clk);
        end
        chk("hold_v", if_def.v_count, v_hold);
        en_def = 1'b1;
        for (i = 0; i < 4 && if_def.h_count == 11'd100; i++) @(negedge clk);
        chk("resume_h", if_def.h_count, 101);
        $display("en hold done, resumed at h=%0d", if_def.h_count);

        // Reset mid-frame
        for (i = 0; i < 2000 && if_def.h_count != 11'd300; i++) @(negedge clk);
        chk("reach_h300", if_def.h_count, 300);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_h", if_def.h_count, 0);
        chk("mid_rst_v", if_def.v_count, 0);
        chk("mid_rst_ctl", {if_def.vga_hs, if_def.vga_vs, if_def.vga_blank_n}, 3'b110);
        rst = 1'b0;
        #1;
        chk("mid_rst_fs0", if_def.frame_start, 0);
        @(negedge clk);
        chk("mid_rst_fs1", if_def.frame_start, 1);
        $display("mid-frame reset recovered at cycle %0d", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0/0, active sync level (0 = active-low).
REQ-006 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel (legal 1..16).
REQ-007 SHALL have parameter PIPE, default 2, pixel-tick delay applied to vga_* outputs (legal 0..8).
REQ-008 SHALL have parameter CNT_W, default 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1.
REQ-009 clk  in  1  system clock; the only clock.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 en  in  1  run enable; low freezes all counters and outputs.
REQ-012 pix_en  out  1  one-clk pixel tick.
REQ-013 h_count / v_count  out  CNT_W  current pixel/line position.
REQ-014 active  out  1  h_count<H_ACTIVE and v_count<V_ACTIVE.
REQ-015 line_start / frame_start  out  1  one-clk strobes.
REQ-016 vga_hs / vga_vs / vga_blank_n  out  1  sync and blank, delayed PIPE ticks.
REQ-017 vga_sync_n  out  1  constant 0.

Function
REQ-018 H_TOTAL = sum of H parameters; V_TOTAL = sum of V parameters; both SHALL be localparams.
REQ-019 Divider SHALL count 0..CLK_DIV-1 on every clk with en=1; pix_en=1 when divider==CLK_DIV-1 and en=1; CLK_DIV=1 gives pix_en=en.
REQ-020 On pix_en, h_count SHALL increment, wrapping H_TOTAL-1 -> 0; on that wrap v_count SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-021 Counters and divider SHALL hold when en=0; resuming continues from held values.
REQ-022 Undelayed hs SHALL be at HS_POL level while H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, else inverse; vs likewise on v_count with V parameters.
REQ-023 active, hs, vs SHALL be decoded combinationally from the registered counts (zero-cycle alignment with h_count/v_count).
REQ-024 line_start SHALL be pix_en && h_count==0; frame_start SHALL be pix_en && h_count==0 && v_count==0.
REQ-025 vga_hs, vga_vs, vga_blank_n SHALL be hs, vs, active passed through PIPE shift stages advancing only on pix_en; PIPE=0 SHALL be pure wires.
REQ-026 Changing en mid-line SHALL not produce glitches or shortened sync pulses at tick granularity.

Reset
REQ-027 On rst: divider=0, h_count=0, v_count=0, every pipeline stage set to inactive sync level and blank_n=0.
REQ-028 First pix_en after rst falls SHALL occur CLK_DIV-1 clks later (en=1).
REQ-029 rst SHALL dominate en; reset mid-frame restarts at (0,0) with no partial sync pulse carried from the pipe.

Structure
REQ-030 A shared package SHALL hold the default timing constants (640x480@60 set and an 800x600@60 set) and the polarity encodings.
REQ-031 One sub-module SHALL be used: vga_delay_line (parametrised width/depth shift register with enable), instanced for the 3-bit {hs,vs,blank_n} bundle.
REQ-032 No derived clocks; all flops on clk.

Verification
REQ-033 Defaults, en=1: frame_start period 840000 clks; line_start period 1600 clks; undelayed hs low for h_count 656..751 (96 ticks).
REQ-034 Small timing H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, PIPE=0: h wraps 7->0, v wraps 5->0, frame 48 clks, vs low exactly at v_count=4.
REQ-035 Same small timing, PIPE=3: vga_hs edges lag undelayed hs edges by exactly 3 clks; first 3 ticks after reset show inactive levels, blank_n=0.
REQ-036 HS_POL=1, VS_POL=1: vga_hs high only during sync window; idle low after reset.
REQ-037 en low for 37 clks at h_count=100: counts hold at 100, no pix_en, resume at 101.
REQ-038 rst asserted at (h=300,v=200): next clk counts 0,0, outputs inactive; frame_start after CLK_DIV-1 clks.
